gci_std_display_vram_controller: RTL and testbench

//  VRAM-side responder for the display VRAM bus driven by the IF0/IF1 arbiter. Grants bus sessions
//  (ARBIT_REQ/ACK/FINISH), queues ENA/RW/ADDR/DATA commands in a command FIFO and issues them to a

---
 rtl/gci_std_display_vram_controller.sv | 201 ++++++++++++++++++++
 tb/tb_gci_std_display_vram_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gci_std_display_vram_controller.sv
// gci_std_display_vram_controller
//   VRAM-side responder on the display VRAM bus. Grants arbiter sessions,
//   queues commands in a small command FIFO and issues them in order to a
//   fixed-latency synchronous SRAM port. Read data comes back in issue order
//   through a response FIFO into a registered output stage.
//
//   Handshakes:
//     command : a command is offered when iENA=1. It is accepted only in
//               SESSION with the command FIFO not full. oBUSY is registered
//               and warns one entry early.
//     read out: a word transfers on a cycle with oVALID=1 and iBUSY=0.
//               While iBUSY=1, oVALID and oDATA hold.
//
//   Ports:
//     iGCI_CLOCK / inRESET (async, active-low) / iRESET_SYNC (sync, active-high)
//     iARBIT_REQ, oARBIT_ACK, iARBIT_FINISH  : session control
//     iENA, oBUSY, iRW, iADDR, iDATA         : command input
//     oVALID, iBUSY, oDATA                   : read data output
//     oMEM_ENA, oMEM_RW, oMEM_ADDR, oMEM_DATA, iMEM_DATA : SRAM port
//     oERR                                   : sticky dropped-command flag
module gci_std_display_vram_controller #(
  parameter int P_MEM_ADDR_N  = 19,
  parameter int P_CMD_DEPTH_N = 2,
  parameter int P_RSP_DEPTH_N = 2,
  parameter int P_RD_LAT      = 2
)(
  input  logic                    iGCI_CLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iARBIT_REQ,
  output logic                    oARBIT_ACK,
  input  logic                    iARBIT_FINISH,
  input  logic                    iENA,
  output logic                    oBUSY,
  input  logic                    iRW,
  input  logic [P_MEM_ADDR_N-1:0] iADDR,
  input  logic [31:0]             iDATA,
  output logic                    oVALID,
  input  logic                    iBUSY,
  output logic [31:0]             oDATA,
  output logic                    oMEM_ENA,
  output logic                    oMEM_RW,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [31:0]             oMEM_DATA,
  input  logic [31:0]             iMEM_DATA,
  output logic                    oERR
);

  localparam int CMD_DEPTH = 1 << P_CMD_DEPTH_N;
  localparam int RSP_DEPTH = 1 << P_RSP_DEPTH_N;
  localparam logic [P_CMD_DEPTH_N:0] CMD_FULL    = (P_CMD_DEPTH_N+1)'(CMD_DEPTH);
  localparam logic [P_CMD_DEPTH_N:0] CMD_BUSY_AT = (P_CMD_DEPTH_N+1)'(CMD_DEPTH - 1);

  typedef struct packed {
    logic                    rw;
    logic [P_MEM_ADDR_N-1:0] addr;
    logic [31:0]             data;
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SESSION, ST_DRAIN} state_t;

  state_t state, stateNext;

  cmd_t                     cmdMem [CMD_DEPTH];
  logic [P_CMD_DEPTH_N-1:0] cmdWrPtr, cmdRdPtr;
  logic [P_CMD_DEPTH_N:0]   cmdCnt, cmdCntNext;
  logic [31:0]              rspMem [RSP_DEPTH];
  logic [P_RSP_DEPTH_N-1:0] rspWrPtr, rspRdPtr;
  logic [P_RSP_DEPTH_N:0]   rspCnt;
  logic [P_RD_LAT-1:0]      rdPipe;

  cmd_t cmdIn, cand;
  logic cmdAccept, cmdEmpty, candValid, creditOk, issue, cmdPush, cmdPop, memRdNow;
  logic retValid, rspEmpty, rspPop, rspBypass, rspPush;
  logic drained, ackNext, busyNext, errNext;
  int   creditUsed;

  // ---------------- command path ----------------
  always_comb begin
    cmdIn     = '{rw: iRW, addr: iADDR, data: iDATA};
    cmdEmpty  = (cmdCnt == '0);
    cmdAccept = iENA && (state == ST_SESSION) && (cmdCnt != CMD_FULL);
    // Empty FIFO falls through so an accepted command issues on the same edge.
    candValid = !cmdEmpty || cmdAccept;
    cand      = cmdEmpty ? cmdIn : cmdMem[cmdRdPtr];
    memRdNow  = oMEM_ENA && !oMEM_RW;
    // Every read that could still land in the response FIFO holds a credit.
    creditUsed = int'(oVALID) + int'(rspCnt) + int'(memRdNow);
    for (int i = 0; i < P_RD_LAT; i++) creditUsed += int'(rdPipe[i]);
    creditOk   = (creditUsed < RSP_DEPTH);
    issue      = candValid && (cand.rw || creditOk);
    cmdPop     = issue && !cmdEmpty;
    cmdPush    = cmdAccept && !(cmdEmpty && issue);
    cmdCntNext = cmdCnt + (P_CMD_DEPTH_N+1)'(cmdPush) - (P_CMD_DEPTH_N+1)'(cmdPop);
  end

  // ---------------- response path ----------------
  always_comb begin
    retValid  = rdPipe[P_RD_LAT-1];
    rspEmpty  = (rspCnt == '0);
    rspPop    = !iBUSY && !rspEmpty;
    rspBypass = !iBUSY && rspEmpty && retValid;
    rspPush   = retValid && !rspBypass;
    drained   = cmdEmpty && !memRdNow && (rdPipe == '0) && rspEmpty && !oVALID;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
    if (!inRESET)         state <= ST_IDLE;
    else if (iRESET_SYNC) state <= ST_IDLE;
    else                  state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (iARBIT_REQ)    stateNext = ST_GRANT;
      ST_GRANT:                      stateNext = ST_SESSION;
      ST_SESSION: if (iARBIT_FINISH) stateNext = ST_DRAIN;
      ST_DRAIN:   if (drained)       stateNext = ST_IDLE;
      default:                       stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    ackNext  = (state == ST_GRANT);
    busyNext = (stateNext != ST_SESSION) || (cmdCntNext >= CMD_BUSY_AT);
    errNext  = iENA && !cmdAccept;
  end

  // ---------------- storage (no reset needed) ----------------
  always_ff @(posedge iGCI_CLOCK) begin
    if (cmdPush) cmdMem[cmdWrPtr] <= cmdIn;
    if (rspPush) rspMem[rspWrPtr] <= iMEM_DATA;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      cmdWrPtr   <= '0;
      cmdRdPtr   <= '0;
      cmdCnt     <= '0;
      rspWrPtr   <= '0;
      rspRdPtr   <= '0;
      rspCnt     <= '0;
      rdPipe     <= '0;
      oARBIT_ACK <= 1'b0;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      if (cmdPush) cmdWrPtr <= cmdWrPtr + (P_CMD_DEPTH_N)'(1);
      if (cmdPop)  cmdRdPtr <= cmdRdPtr + (P_CMD_DEPTH_N)'(1);
      cmdCnt <= cmdCntNext;
      if (rspPush) rspWrPtr <= rspWrPtr + (P_RSP_DEPTH_N)'(1);
      if (rspPop)  rspRdPtr <= rspRdPtr + (P_RSP_DEPTH_N)'(1);
      rspCnt <= rspCnt + (P_RSP_DEPTH_N+1)'(rspPush) - (P_RSP_DEPTH_N+1)'(rspPop);
      // rdPipe[0] marks the cycle after oMEM_ENA; the last stage marks iMEM_DATA valid.
      rdPipe[0] <= memRdNow;
      for (int i = 1; i < P_RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
      oARBIT_ACK <= ackNext;
      oBUSY      <= busyNext;
      if (errNext) oERR <= 1'b1;
    end
  end

  // ---------------- SRAM port ----------------
  always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      oMEM_ENA  <= 1'b0;
      oMEM_RW   <= 1'b0;
      oMEM_ADDR <= '0;
      oMEM_DATA <= '0;
    end else if (issue) begin
      oMEM_ENA  <= 1'b1;
      oMEM_RW   <= cand.rw;
      oMEM_ADDR <= cand.addr;
      oMEM_DATA <= cand.data;
    end else begin
      oMEM_ENA  <= 1'b0;
    end
  end

  // ---------------- read output stage ----------------
  always_ff @(posedge iGCI_CLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) begin
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else if (!iBUSY) begin
      if (!rspEmpty) begin
        oVALID <= 1'b1;
        oDATA  <= rspMem[rspRdPtr];
      end else if (retValid) begin
        oVALID <= 1'b1;
        oDATA  <= iMEM_DATA;
      end else begin
        oVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gci_std_display_vram_controller.sv
// Bench for gci_std_display_vram_controller: SRAM model, reference memory,
// expected queues for SRAM commands and read data, negedge monitor.
module tb_gci_std_display_vram_controller;

  localparam int AW  = 19;
  localparam int LAT = 2;
  localparam int MW  = 1 + AW + 32;

  logic          clk = 1'b0;
  logic          inRESET, iRESET_SYNC, iARBIT_REQ, iARBIT_FINISH, iENA, iRW, iBUSY;
  logic [AW-1:0] iADDR;
  logic [31:0]   iDATA, iMEM_DATA;
  logic          oARBIT_ACK, oBUSY, oVALID, oMEM_ENA, oMEM_RW, oERR;
  logic [31:0]   oDATA, oMEM_DATA;
  logic [AW-1:0] oMEM_ADDR;

  gci_std_display_vram_controller #(
    .P_MEM_ADDR_N(AW), .P_CMD_DEPTH_N(2), .P_RSP_DEPTH_N(2), .P_RD_LAT(LAT)
  ) dut (
    .iGCI_CLOCK(clk), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iARBIT_REQ(iARBIT_REQ), .oARBIT_ACK(oARBIT_ACK), .iARBIT_FINISH(iARBIT_FINISH),
    .iENA(iENA), .oBUSY(oBUSY), .iRW(iRW), .iADDR(iADDR), .iDATA(iDATA),
    .oVALID(oVALID), .iBUSY(iBUSY), .oDATA(oDATA),
    .oMEM_ENA(oMEM_ENA), .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_DATA(oMEM_DATA), .iMEM_DATA(iMEM_DATA), .oERR(oERR)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int nAsserts = 0;
  int nFails   = 0;
  logic [31:0]   expRsp[$];
  logic [MW-1:0] expMem[$];
  logic [31:0]   refMem[int];
  logic [31:0]   sramMem[int];

  int   lastValidCyc = -1, memRdCyc = -1, memRdCount = 0, validCount = 0;
  logic prevAck = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name, input logic [63:0] act);
    nAsserts++;
    nFails++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [31:0] dflt(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {13'h0, a};
  endfunction

  // ---------------- SRAM model ----------------
  logic [31:0] sramNow;
  logic [31:0] sramPipe [LAT];

  always @(negedge clk) begin
    sramNow = $urandom;
    if (oMEM_ENA) begin
      if (oMEM_RW) sramMem[int'(oMEM_ADDR)] = oMEM_DATA;
      else sramNow = sramMem.exists(int'(oMEM_ADDR)) ? sramMem[int'(oMEM_ADDR)] : dflt(oMEM_ADDR);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = LAT - 1; k > 0; k--) sramPipe[k] = sramPipe[k-1];
    sramPipe[0] = sramNow;
    iMEM_DATA   = sramPipe[LAT-1];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (inRESET && !iRESET_SYNC) begin
      if (oVALID && !iBUSY) begin
        validCount++;
        lastValidCyc = cyc;
        if (expRsp.size() == 0) failNow("rsp_unexpected", {32'h0, oDATA});
        else check("rsp_data", {32'h0, oDATA}, {32'h0, expRsp.pop_front()});
      end
      if (oMEM_ENA) begin
        if (!oMEM_RW) begin
          memRdCount++;
          memRdCyc = cyc;
        end
        if (expMem.size() == 0) failNow("mem_unexpected", {12'h0, oMEM_RW, oMEM_ADDR, oMEM_DATA});
        else check("mem_cmd", 64'({oMEM_RW, oMEM_ADDR, (oMEM_RW ? oMEM_DATA : 32'h0)}),
                   64'(expMem.pop_front()));
      end
      if (oARBIT_ACK) check("ack_pulse_width", 64'(prevAck), 64'(0));
      prevAck = oARBIT_ACK;
    end else begin
      prevAck = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendCmd(input logic rw, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic fin, output int drvCyc);
    int n = 0;
    while (oBUSY && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) failNow("cmd_busy_timeout", 64'(n));
    iENA = 1'b1; iRW = rw; iADDR = a; iDATA = d; iARBIT_FINISH = fin;
    drvCyc = cyc;
    expMem.push_back({rw, a, (rw ? d : 32'h0)});
    if (rw) refMem[int'(a)] = d;
    else expRsp.push_back(refMem.exists(int'(a)) ? refMem[int'(a)] : dflt(a));
    step(1);
    iENA = 1'b0; iARBIT_FINISH = 1'b0;
  endtask

  task automatic openSession(output int lat, output logic busyAtAck, output int ackAt);
    int start;
    int n = 0;
    iARBIT_REQ = 1'b1;
    start = cyc;
    busyAtAck = 1'b1;
    while (n < 60) begin
      @(negedge clk);
      if (oARBIT_ACK) break;
      n++;
    end
    if (n >= 60) failNow("ack_timeout", 64'(n));
    lat = cyc - start;
    ackAt = cyc;
    busyAtAck = oBUSY;
    @(posedge clk);
    #1;
    iARBIT_REQ = 1'b0;
  endtask

  task automatic closeSession();
    iARBIT_FINISH = 1'b1;
    step(1);
    iARBIT_FINISH = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expRsp.size() != 0 || expMem.size() != 0) && n < 500) begin
      step(1);
      n++;
    end
    if (n >= 500) failNow("drain_timeout", 64'(expRsp.size()));
    step(2);
  endtask

  task automatic checkAllZero(input string pfx);
    check({pfx, "_ack"},      64'(oARBIT_ACK), 64'(0));
    check({pfx, "_busy"},     64'(oBUSY),      64'(0));
    check({pfx, "_valid"},    64'(oVALID),     64'(0));
    check({pfx, "_data"},     64'(oDATA),      64'(0));
    check({pfx, "_mem_ena"},  64'(oMEM_ENA),   64'(0));
    check({pfx, "_mem_rw"},   64'(oMEM_RW),    64'(0));
    check({pfx, "_mem_addr"}, 64'(oMEM_ADDR),  64'(0));
    check({pfx, "_mem_data"}, 64'(oMEM_DATA),  64'(0));
    check({pfx, "_err"},      64'(oERR),       64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, ackAt, drv, d0, rc0, vc0;
    logic busyAck;
    logic done;

    inRESET = 1'b0; iRESET_SYNC = 1'b0; iARBIT_REQ = 1'b0; iARBIT_FINISH = 1'b0;
    iENA = 1'b0; iRW = 1'b0; iADDR = '0; iDATA = '0; iBUSY = 1'b0; iMEM_DATA = '0;
    sramMem[32'h12] = 32'hDEAD_BEEF;
    refMem[32'h12]  = 32'hDEAD_BEEF;

    // Reset state.
    step(3);
    checkAllZero("reset");
    inRESET = 1'b1;
    step(2);
    check("idle_busy", 64'(oBUSY), 64'(1));
    check("idle_ack",  64'(oARBIT_ACK), 64'(0));

    // Grant: ACK two cycles after REQ, oBUSY low in SESSION.
    openSession(lat, busyAck, ackAt);
    check("grant_latency", 64'(lat), 64'(2));
    check("grant_busy_low", 64'(busyAck), 64'(0));

    // Write burst addr 0..5, data A0..A5.
    for (int i = 0; i < 6; i++) sendCmd(1'b1, AW'(i), 32'hA0 + 32'(i), 1'b0, drv);
    waitDrain();
    check("burst_no_err", 64'(oERR), 64'(0));

    // Single read latency.
    sendCmd(1'b0, AW'(32'h12), 32'h0, 1'b0, drv);
    waitDrain();
    check("rd_lat_mem",   64'(memRdCyc),     64'(drv + 1));
    check("rd_lat_valid", 64'(lastValidCyc), 64'(drv + LAT + 2));

    // Backpressure: 8 reads with requester stalled.
    iBUSY = 1'b1;
    rc0 = memRdCount;
    vc0 = validCount;
    fork
      begin
        for (int i = 0; i < 8; i++) sendCmd(1'b0, AW'(32'h40 + i), 32'h0, 1'b0, d0);
      end
      begin
        step(25);
        check("bp_reads_issued", 64'(memRdCount - rc0), 64'(4));
        check("bp_busy_high",    64'(oBUSY),            64'(1));
        check("bp_no_valid",     64'(validCount - vc0), 64'(0));
        iBUSY = 1'b0;
      end
    join
    waitDrain();
    check("bp_all_returned", 64'(validCount - vc0), 64'(8));

    // Random mix of reads/writes with random requester stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          sendCmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 1'b0, d0);
          if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          iBUSY = ($urandom_range(0, 3) == 0);
          step(1);
        end
      end
    join
    iBUSY = 1'b0;
    waitDrain();
    check("random_no_err", 64'(oERR), 64'(0));

    // Drain: FINISH together with the second read, REQ held during DRAIN.
    sendCmd(1'b0, AW'(3), 32'h0, 1'b0, d0);
    sendCmd(1'b0, AW'(7), 32'h0, 1'b1, d0);
    openSession(lat, busyAck, ackAt);
    check("drain_rsp_before_ack", 64'(expRsp.size()), 64'(0));
    check("drain_ack_after_valid", 64'(ackAt > lastValidCyc), 64'(1));
    check("drain_regrant_busy_low", 64'(busyAck), 64'(0));

    // Command outside a session is dropped and flags oERR.
    closeSession();
    step(10);
    iENA = 1'b1; iRW = 1'b1; iADDR = AW'(5); iDATA = 32'h5555_5555;
    step(1);
    iENA = 1'b0;
    step(1);
    check("err_outside_session", 64'(oERR), 64'(1));

    // Sync reset with three reads outstanding.
    openSession(lat, busyAck, ackAt);
    iBUSY = 1'b1;
    for (int i = 0; i < 3; i++) sendCmd(1'b0, AW'(i), 32'h0, 1'b0, d0);
    iRESET_SYNC = 1'b1;
    step(1);
    checkAllZero("sync_reset");
    expRsp.delete();
    expMem.delete();
    iRESET_SYNC = 1'b0;
    iBUSY = 1'b0;
    vc0 = validCount;
    step(15);
    check("no_valid_after_sync_reset", 64'(validCount - vc0), 64'(0));
    check("post_reset_idle_busy", 64'(oBUSY), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
